// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequencing controller for the five-stage RV64 pipeline. Owns every stage
// register enable, IF/ID flush, ID/EX bubble, the PC update/redirect, the
// registered EX operand forward selects, and a two-entry (EX, MEM) scoreboard
// of in-flight destination registers.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_if_req/i_imem_data_ok imem request outstanding / data returned
//   i_dmem_req/i_dmem_data_ok MEM stage data access / access completes
//   i_id_*                  decoded fields of the instruction held in ID
//   i_ex_redirect/i_ex_target EX changes PC / redirect target
//   o_pc_en/o_pc_redirect/o_pc_target  PC control
//   o_ifid_en/o_idex_en/o_exmem_en/o_memwb_en  stage register enables
//   o_ifid_flush/o_idex_bubble/o_fetch_discard  squash controls
//   o_fwd_a/o_fwd_b         EX forward selects (0 regfile, 1 EX/MEM, 2 MEM/WB)
//   o_hz_state              FSM state (0 RUN, 1 IWAIT, 2 IDROP)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_if_req,
  input  logic            i_imem_data_ok,
  input  logic            i_dmem_req,
  input  logic            i_dmem_data_ok,
  input  logic            i_id_valid,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic            i_id_use_rs1,
  input  logic            i_id_use_rs2,
  input  logic [4:0]      i_id_rd,
  input  logic            i_id_regwen,
  input  logic            i_id_is_load,
  input  logic            i_ex_redirect,
  input  logic [XLEN-1:0] i_ex_target,
  output logic            o_pc_en,
  output logic            o_pc_redirect,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_ifid_en,
  output logic            o_idex_en,
  output logic            o_exmem_en,
  output logic            o_memwb_en,
  output logic            o_ifid_flush,
  output logic            o_idex_bubble,
  output logic            o_fetch_discard,
  output logic [1:0]      o_fwd_a,
  output logic [1:0]      o_fwd_b,
  output logic [1:0]      o_hz_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_IDROP = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwen;
    logic       is_load;
  } sb_entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_tgt;
  logic [XLEN-1:0]   w_tgt_nxt;
  sb_entry_t         r_ex;
  sb_entry_t         r_mem;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;

  logic              w_dmem_busy;
  logic              w_imem_busy;
  logic              w_acc;
  logic              w_load_use;
  sb_entry_t         w_id_entry;

  // Forward select for one source; x0 never matches, EX entry wins over MEM.
  // A load in EX cannot forward: its data does not exist until MEM completes.
  function automatic logic [1:0] fwd_sel(
    input logic       use_rs,
    input logic [4:0] rs,
    input sb_entry_t  ex_e,
    input sb_entry_t  mem_e
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (!use_rs || (rs == 5'd0)) begin
      sel = 2'd0;
    end else if (ex_e.valid && ex_e.regwen && !ex_e.is_load && (ex_e.rd == rs)) begin
      sel = 2'd1;
    end else if (mem_e.valid && mem_e.regwen && (mem_e.rd == rs)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign w_dmem_busy = i_dmem_req & ~i_dmem_data_ok;
  assign w_imem_busy = i_if_req & ~i_imem_data_ok;
  assign w_acc       = i_ex_redirect & ~w_dmem_busy;

  assign w_load_use = i_id_valid & r_ex.valid & r_ex.is_load & (r_ex.rd != 5'd0) &
                      ((i_id_use_rs1 & (i_id_rs1 == r_ex.rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == r_ex.rd)));

  assign w_id_entry = '{valid: i_id_valid, rd: i_id_rd, regwen: i_id_regwen,
                        is_load: i_id_is_load};

  // Registered values are masked while reset is high so the reset-cycle
  // outputs are defined before the first reset edge is seen.
  assign o_fwd_a    = i_reset ? 2'd0 : r_fwd_a;
  assign o_fwd_b    = i_reset ? 2'd0 : r_fwd_b;
  assign o_hz_state = i_reset ? 2'd0 : r_state;

  // Hazard resolution: enables, squashes, PC control and next FSM state.
  always_comb begin
    o_pc_en         = 1'b0;
    o_pc_redirect   = 1'b0;
    o_pc_target     = '0;
    o_ifid_en       = 1'b0;
    o_idex_en       = 1'b0;
    o_exmem_en      = 1'b0;
    o_memwb_en      = 1'b0;
    o_ifid_flush    = 1'b0;
    o_idex_bubble   = 1'b0;
    o_fetch_discard = 1'b0;
    w_state_nxt     = r_state;
    w_tgt_nxt       = r_tgt;
    if (i_reset) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (w_dmem_busy) begin
      // Full freeze: the redirect in EX stays asserted and is taken later.
      w_state_nxt = r_state;
    end else begin
      o_idex_en  = 1'b1;
      o_exmem_en = 1'b1;
      o_memwb_en = 1'b1;
      if (w_acc) begin
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
        if (w_imem_busy || (r_state == ST_IDROP)) begin
          // The in-flight fetch is from the wrong path: park the target
          // until its data arrives and can be thrown away.
          w_tgt_nxt   = i_ex_target;
          w_state_nxt = ST_IDROP;
        end else begin
          o_pc_en       = 1'b1;
          o_pc_redirect = 1'b1;
          o_pc_target   = i_ex_target;
          w_state_nxt   = ST_RUN;
        end
      end else if (r_state == ST_IDROP) begin
        o_idex_bubble = 1'b1;
        if (i_imem_data_ok) begin
          o_fetch_discard = 1'b1;
          o_ifid_flush    = 1'b1;
          o_pc_en         = 1'b1;
          o_pc_redirect   = 1'b1;
          o_pc_target     = r_tgt;
          w_state_nxt     = ST_RUN;
        end else begin
          w_state_nxt = ST_IDROP;
        end
      end else if (w_load_use) begin
        o_idex_bubble = 1'b1;
        w_state_nxt   = w_imem_busy ? ST_IWAIT : ST_RUN;
      end else if (w_imem_busy) begin
        o_idex_bubble = 1'b1;
        w_state_nxt   = ST_IWAIT;
      end else begin
        o_pc_en     = 1'b1;
        o_ifid_en   = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end
  end

  // State, latched target, scoreboard and forward-select registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_tgt   <= '0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_fwd_a <= 2'd0;
      r_fwd_b <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      if (o_idex_en) begin
        // Selects are computed against the entries the ID instruction will
        // trail by one (now EX -> EX/MEM) and two (now MEM -> MEM/WB) stages.
        r_ex    <= o_idex_bubble ? '0 : w_id_entry;
        r_fwd_a <= o_idex_bubble ? 2'd0 : fwd_sel(i_id_use_rs1, i_id_rs1, r_ex, r_mem);
        r_fwd_b <= o_idex_bubble ? 2'd0 : fwd_sel(i_id_use_rs2, i_id_rs2, r_ex, r_mem);
      end
      if (o_exmem_en) begin
        r_mem <= r_ex;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed self-checking bench for pipeline_hazard_ctrl. Inputs are driven
// 1 ns after the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        if_req, imem_data_ok, dmem_req, dmem_data_ok;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwen, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect;
  logic [63:0] ex_target;
  logic        pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, fetch_discard;
  logic [63:0] pc_target;
  logic [1:0]  fwd_a, fwd_b, hz_state;

  int n_checks;
  int n_errors;

  pipeline_hazard_ctrl #(.XLEN(64)) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_imem_data_ok(imem_data_ok),
    .i_dmem_req(dmem_req), .i_dmem_data_ok(dmem_data_ok),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_rd(id_rd), .i_id_regwen(id_regwen), .i_id_is_load(id_is_load),
    .i_ex_redirect(ex_redirect), .i_ex_target(ex_target),
    .o_pc_en(pc_en), .o_pc_redirect(pc_redirect), .o_pc_target(pc_target),
    .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
    .o_memwb_en(memwb_en), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_fetch_discard(fetch_discard),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_hz_state(hz_state)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwen = wen; id_is_load = ld;
  endtask

  task automatic chk_fe(input string tag, input logic pe, input logic fe,
                        input logic bub, input logic fl);
    check_val({tag, ".pc_en"}, {63'd0, pc_en}, {63'd0, pe});
    check_val({tag, ".ifid_en"}, {63'd0, ifid_en}, {63'd0, fe});
    check_val({tag, ".bubble"}, {63'd0, idex_bubble}, {63'd0, bub});
    check_val({tag, ".flush"}, {63'd0, ifid_flush}, {63'd0, fl});
  endtask

  task automatic chk_back(input string tag, input logic en);
    check_val({tag, ".idex_en"}, {63'd0, idex_en}, {63'd0, en});
    check_val({tag, ".exmem_en"}, {63'd0, exmem_en}, {63'd0, en});
    check_val({tag, ".memwb_en"}, {63'd0, memwb_en}, {63'd0, en});
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    check_val({tag, ".fwd_a"}, {62'd0, fwd_a}, {62'd0, a});
    check_val({tag, ".fwd_b"}, {62'd0, fwd_b}, {62'd0, b});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    if_req = 1'b0; imem_data_ok = 1'b0; dmem_req = 1'b0; dmem_data_ok = 1'b0;
    ex_redirect = 1'b0; ex_target = 64'd0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);

    // Reset outputs.
    nxt(); smp();
    chk_fe("rst", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_back("rst", 1'b0);
    chk_fwd("rst", 2'd0, 2'd0);
    check_val("rst.hz", {62'd0, hz_state}, 64'd0);
    check_val("rst.redir", {63'd0, pc_redirect}, 64'd0);
    nxt(); reset = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    smp();
    chk_fe("idle", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_back("idle", 1'b1);

    // add x5,x1,x2 ; sub x7,x5,x3 ; or x8,x4,x5
    nxt(); set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    smp(); chk_fe("add", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt(); set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
    smp(); chk_fe("sub_id", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt(); set_id(1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
    smp(); chk_fwd("sub_ex", 2'd1, 2'd0);
    nxt(); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    smp(); chk_fwd("or_ex", 2'd0, 2'd2);

    // ld x6 ; add x9,x6,x6 -> one bubble, then MEM/WB forwarding
    nxt(); set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    smp(); chk_fe("ld", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt(); set_id(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    smp(); chk_fe("lu_stall", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_back("lu_stall", 1'b1);
    nxt();
    smp(); chk_fe("lu_go", 1'b1, 1'b1, 1'b0, 1'b0);

    // add in EX; dmem busy freezes everything for 3 cycles
    nxt(); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk_fwd($sformatf("frz%0d", i), 2'd2, 2'd2);
      chk_back($sformatf("frz%0d", i), 1'b0);
      chk_fe($sformatf("frz%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      nxt();
    end
    // EX entry (add x9) must have survived the freeze.
    dmem_req = 1'b0;
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    smp(); chk_back("thaw", 1'b1);
    chk_fe("thaw", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt(); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    smp(); chk_fwd("thaw_ex", 2'd1, 2'd0);

    // ld x0 ; use x0 -> no stall, no forward
    nxt(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    nxt(); set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
    smp(); chk_fe("x0_id", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt(); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    smp(); chk_fwd("x0_ex", 2'd0, 2'd0);

    // Redirect with imem idle.
    nxt(); ex_redirect = 1'b1; ex_target = 64'h0000_0000_8000_0040;
    smp(); chk_fe("redir", 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("redir.pcr", {63'd0, pc_redirect}, 64'd1);
    check_val("redir.tgt", pc_target, 64'h0000_0000_8000_0040);

    // Plain imem wait -> IWAIT.
    nxt(); ex_redirect = 1'b0; if_req = 1'b1;
    smp(); chk_fe("iwait", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt();
    smp(); check_val("iwait.hz", {62'd0, hz_state}, 64'd1);
    nxt(); imem_data_ok = 1'b1;
    smp(); chk_fe("iwait_ok", 1'b1, 1'b1, 1'b0, 1'b0);
    nxt(); if_req = 1'b0; imem_data_ok = 1'b0;
    smp(); check_val("iwait_end.hz", {62'd0, hz_state}, 64'd0);

    // Redirect while a fetch is outstanding for 4 cycles.
    nxt(); if_req = 1'b1; ex_redirect = 1'b1; ex_target = 64'h0000_0000_8000_0100;
    smp(); chk_fe("rd_busy", 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("rd_busy.pcr", {63'd0, pc_redirect}, 64'd0);
    nxt(); ex_redirect = 1'b0; ex_target = 64'h0000_0000_0000_dead;
    smp(); check_val("idrop1.hz", {62'd0, hz_state}, 64'd2);
    chk_fe("idrop1", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt();
    smp(); check_val("idrop2.hz", {62'd0, hz_state}, 64'd2);
    nxt(); imem_data_ok = 1'b1;
    smp(); check_val("drop.disc", {63'd0, fetch_discard}, 64'd1);
    check_val("drop.pcr", {63'd0, pc_redirect}, 64'd1);
    check_val("drop.tgt", pc_target, 64'h0000_0000_8000_0100);
    chk_fe("drop", 1'b1, 1'b0, 1'b1, 1'b1);
    nxt(); if_req = 1'b0; imem_data_ok = 1'b0;
    smp(); check_val("drop_end.hz", {62'd0, hz_state}, 64'd0);
    check_val("drop_end.disc", {63'd0, fetch_discard}, 64'd0);

    // Second redirect in IDROP overwrites the latched target.
    nxt(); if_req = 1'b1; ex_redirect = 1'b1; ex_target = 64'h0000_0000_8000_0200;
    nxt(); ex_target = 64'h0000_0000_8000_0300;
    smp(); check_val("ovr.pcr", {63'd0, pc_redirect}, 64'd0);
    chk_fe("ovr", 1'b0, 1'b0, 1'b1, 1'b1);
    nxt(); ex_redirect = 1'b0; imem_data_ok = 1'b1;
    smp(); check_val("ovr.tgt", pc_target, 64'h0000_0000_8000_0300);
    check_val("ovr.disc", {63'd0, fetch_discard}, 64'd1);

    // Reset mid-IDROP drops the pending redirect.
    nxt(); imem_data_ok = 1'b0; ex_redirect = 1'b1; ex_target = 64'h0000_0000_8000_0400;
    nxt(); ex_redirect = 1'b0;
    smp(); check_val("rst_drop.hz", {62'd0, hz_state}, 64'd2);
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; imem_data_ok = 1'b1;
    smp(); check_val("rst_drop.pcr", {63'd0, pc_redirect}, 64'd0);
    check_val("rst_drop.disc", {63'd0, fetch_discard}, 64'd0);
    check_val("rst_drop.hz2", {62'd0, hz_state}, 64'd0);
    check_val("rst_drop.pc_en", {63'd0, pc_en}, 64'd1);

    nxt();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage RV64 pipeline. It sits beside the decoder and owns every stage-register enable, flush and bubble. It also owns the operand-forwarding selects, and tracks in-flight destination registers in a two-entry scoreboard (EX, MEM). It resolves load-use hazards, EX-stage redirects (branch, jal, jalr) and instruction/data memory wait handshakes, including a redirect that arrives while a fetch is still outstanding.

## Interface
- XLEN, 64, PC/target width

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  IF has an imem request outstanding this cycle
- imem_data_ok  in  1  imem returns data this cycle
- dmem_req  in  1  MEM stage issuing a data access
- dmem_data_ok  in  1  dmem access completes this cycle
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
- id_rd  in  5  ID destination register
- id_regwen  in  1  ID writes rd (decoder RegWEn)
- id_is_load  in  1  ID is a load (MemRW==2'b10)
- ex_redirect  in  1  EX instruction changes PC (PCSel)
- ex_target  in  XLEN  redirect target from EX
- pc_en  out  1  PC register updates
- pc_redirect  out  1  PC loads pc_target instead of sequential PC
- pc_target  out  XLEN  redirect target (ex_target or latched copy)
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register enables
- ifid_flush  out  1  clear IF/ID; overrides ifid_en
- idex_bubble  out  1  load zeros into ID/EX
- fetch_discard  out  1  drop the imem data returned this cycle
- fwd_a, fwd_b  out  2 each  registered forward selects for the EX operands: 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result
- hz_state  out  2  FSM state: 0 RUN, 1 IWAIT, 2 IDROP

## Operation
- Signals:
  - dmem_busy = dmem_req & ~dmem_data_ok
  - imem_busy = if_req & ~imem_data_ok
  - redirect accepted (acc) = ex_redirect & ~dmem_busy
- dmem_busy: full freeze.
  - All enables 0; flush, bubble, pc_redirect 0.
  - Scoreboard, fwd and FSM hold.
  - ex_redirect stays asserted because EX is frozen, and is acted on in the first non-busy cycle.
- Otherwise idex_en = exmem_en = memwb_en = 1. Front-end priority, highest first:
  - acc: ifid_flush = 1, idex_bubble = 1.
    - If imem_busy or state IDROP: latch ex_target, go to IDROP, pc_en = 0.
    - Else: pc_en = 1, pc_redirect = 1, pc_target = ex_target.
  - state IDROP: pc_en = 0, ifid_en = 0, idex_bubble = 1.
    - On imem_data_ok: fetch_discard = 1, ifid_flush = 1, pc_en = 1, pc_redirect = 1, pc_target = latched target, go to RUN.
  - Load-use: EX entry valid, is_load, rd != 0, and (id_use_rs1 & id_rs1 == rd, or id_use_rs2 & id_rs2 == rd), with id_valid.
    - pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - imem_busy: pc_en = 0, ifid_en = 0, idex_bubble = 1, state IWAIT.
  - Else: pc_en = 1, ifid_en = 1, state RUN.
- FSM:
  - RUN/IWAIT follow imem_busy.
  - IDROP is left only on imem_data_ok while ~dmem_busy.
  - A second accepted redirect while in IDROP overwrites the latched target.
- Scoreboard entry = {valid, rd, regwen, is_load}.
  - When idex_en: EX entry <= idex_bubble ? 0 : ID fields (valid = id_valid).
  - When exmem_en: MEM entry <= EX entry.
- Forward selects, computed per source when idex_en (0 if idex_bubble or the source is unused):
  - 1 if the EX entry is valid, regwen, not a load, and rd == rs != 0.
  - Else 2 if the MEM entry is valid, regwen, and rd == rs != 0.
  - Else 0.
  - EX entry beats MEM entry when both match.
- x0 never matches any hazard or forward check.

## Timing
- Reset (synchronous): scoreboard cleared, fwd_a = fwd_b = 0, state RUN, latched target 0.
- While reset is high, outputs are: pc_en 0, ifid_flush 1, idex_bubble 1, all other outputs 0.
- All hazard outputs except fwd_a/fwd_b are combinational in the same cycle.
- fwd_a/fwd_b are registered: valid in the cycle the instruction occupies EX.
- Load-use costs exactly 1 bubble. The consumer then sees fwd = 2.
- A redirect with a free fetch costs 2 bubbles (IF/ID and ID/EX flushed).
- A redirect during an outstanding fetch completes the PC update in the imem_data_ok cycle.
- Reset asserted mid-IDROP drops the pending redirect.

## Test plan
- add x5 followed by sub using x5: fwd_a = 1 in the sub EX cycle; no stall.
- ld x6 followed by add using x6: one cycle with pc_en = 0, ifid_en = 0, idex_bubble = 1; next cycle fwd = 2.
- dmem_req held for 3 cycles with no data_ok: all enables 0 for 3 cycles, with scoreboard and fwd unchanged.
- ex_redirect with imem idle and ex_target = 0x80000040: pc_redirect = 1, pc_target = 0x80000040, ifid_flush = 1, idex_bubble = 1.
- ex_redirect to 0x80000100 while if_req is pending for 4 cycles: hz_state = 2, then on data_ok fetch_discard = 1 and pc_target = 0x80000100.
- Load to x0 followed by a use of x0: no stall, fwd = 0.
